// File: rtl/msx_slot_initiator.sv
// MSX cartridge slot bus initiator.
// Turns single request/response transfers into MSX slot bus cycles built from
// SETUP, STROBE and HOLD phases. The responder may stretch the strobe with
// slot_wait, and a wait budget forces completion if it never lets go.
module msx_slot_initiator #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int WAIT_MAX   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mem,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [15:0] slot_a,
  output logic [7:0]  slot_d_out,
  output logic        slot_d_oe,
  input  logic [7:0]  slot_d_in,
  output logic        slot_sltsl_n,
  output logic        slot_mereq_n,
  output logic        slot_ioreq_n,
  output logic        slot_rd_n,
  output logic        slot_wr_n,
  input  logic        slot_wait
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // Terminal counts for the shared phase counter and the wait budget.
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] WAIT_LIM    = 8'(WAIT_MAX);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] wait_reg, wait_next;
  logic       mem_reg, wr_reg, timeout_reg;
  logic       accept, strobe_done, timed_out, sel;

  // State and counter registers; an asynchronous reset drops straight to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      wait_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wait_reg  <= wait_next;
    end
  end

  // Next-state logic plus the bus controls, which decode directly from the
  // state so that a reset releases the bus in the same cycle.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    wait_next   = wait_reg;
    accept      = 1'b0;
    strobe_done = 1'b0;
    timed_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
          cnt_next   = 8'd0;
          wait_next  = 8'd0;
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          state_next = STROBE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      STROBE: begin
        // Wait cycles are excluded from the strobe count but consume budget.
        if (slot_wait) begin
          wait_next = wait_reg + 8'd1;
          if (wait_next == WAIT_LIM) begin
            timed_out   = 1'b1;
            strobe_done = 1'b1;
            state_next  = HOLD;
            cnt_next    = 8'd0;
          end
        end else if (cnt_reg == STROBE_LAST) begin
          strobe_done = 1'b1;
          state_next  = HOLD;
          cnt_next    = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase

    sel          = (state_reg == SETUP) || (state_reg == STROBE);
    req_ready    = (state_reg == IDLE);
    rsp_valid    = (state_reg == HOLD) && (cnt_reg == 8'd0);
    rsp_timeout  = rsp_valid && timeout_reg;
    slot_sltsl_n = !(sel && mem_reg);
    slot_mereq_n = !(sel && mem_reg);
    slot_ioreq_n = !(sel && !mem_reg);
    slot_rd_n    = !((state_reg == STROBE) && !wr_reg);
    slot_wr_n    = !((state_reg == STROBE) && wr_reg);
    slot_d_oe    = (state_reg != IDLE) && wr_reg;
  end

  // Request latch at acceptance; read data and timeout flag at strobe end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_reg     <= 1'b0;
      wr_reg      <= 1'b0;
      timeout_reg <= 1'b0;
      slot_a      <= 16'h0000;
      slot_d_out  <= 8'h00;
      rsp_rdata   <= 8'h00;
    end else begin
      if (accept) begin
        mem_reg     <= req_mem;
        wr_reg      <= req_wr;
        timeout_reg <= 1'b0;
        slot_a      <= req_addr;
        slot_d_out  <= req_wdata;
      end
      if (strobe_done) begin
        timeout_reg <= timed_out;
        if (!wr_reg) begin
          rsp_rdata <= slot_d_in;
        end
      end
    end
  end

endmodule
